// File: rtl/fib_producer_ctrl.sv
// fib_producer_ctrl: producer-side sequencer for the Fibonacci generator.
// It pulses the generator once per word, forwards words over a 4-phase req/ack handshake, and aborts on 16-bit wrap-around.
module fib_producer_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock_1,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  burst_len,
    output logic        f_en,
    input  logic        f_valid,
    input  logic [15:0] f_out,
    output logic        req,
    output logic [15:0] data_out,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic        overflow
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] GEN    = 3'd1;
    localparam logic [2:0] WAIT_V = 3'd2;
    localparam logic [2:0] REQ    = 3'd3;
    localparam logic [2:0] REL    = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]             state, nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   ack_s;
    logic [5:0]             cnt, len, cnt_inc;
    logic [15:0]            prev;

    assign ack_s   = sync[SYNC_STAGES-1];
    assign cnt_inc = cnt + 6'd1;

    always_ff @(posedge clock_1 or posedge reset)
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], ack};

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (start && !overflow) ? GEN : IDLE;
            GEN:     nxt = WAIT_V;
            WAIT_V:  nxt = !f_valid ? WAIT_V : (f_out < prev) ? DONE : REQ;
            REQ:     nxt = ack_s ? REL : REQ;
            REL:     nxt = ack_s ? REL : (cnt_inc == len) ? DONE : GEN;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clock_1 or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            f_en     <= 1'b0;
            req      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            data_out <= '0;
            prev     <= '0;
            cnt      <= '0;
            len      <= '0;
        end else begin
            state <= nxt;
            f_en  <= nxt == GEN;
            req   <= nxt == REQ;
            done  <= nxt == DONE;
            busy  <= nxt != IDLE;
            if (state == IDLE && nxt == GEN) begin
                len <= (burst_len == 5'd0) ? 6'd32 : {1'b0, burst_len};
                cnt <= '0;
            end
            if (state == WAIT_V && f_valid) begin
                if (f_out < prev) overflow <= 1'b1;
                else begin
                    data_out <= f_out;
                    prev     <= f_out;
                end
            end
            if (state == REL && !ack_s) cnt <= cnt_inc;
        end
    end
endmodule

// File: tb/tb_fib_producer_ctrl.sv
// tb_fib_producer_ctrl: scoreboard bench with a Fibonacci generator model and a configurable-latency consumer.
module tb_fib_producer_ctrl;
    logic        clock_1 = 0, reset = 1, start = 0, f_valid = 0, ack = 0;
    logic [4:0]  burst_len = 0;
    logic [15:0] f_out = 0, data_out, held = 0, ga = 0, gb = 1;
    logic        f_en, req, busy, done, overflow, req_q = 0;
    logic [15:0] exp_q[$];
    logic [15:0] fib [0:25] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21,
                                16'd34, 16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610, 16'd987,
                                16'd1597, 16'd2584, 16'd4181, 16'd6765, 16'd10946, 16'd17711,
                                16'd28657, 16'd46368, 16'd9489};
    int checks = 0, errors = 0;
    int cyc = 0, fen_cnt = 0, done_cnt = 0, words = 0;
    int ack_dly = 3, rel_dly = 3, ack_cyc = 0, fall_cyc = 0, cs = 0, ccnt = 0;
    int f0, d0, w0, t;

    always #5 clock_1 = ~clock_1;

    fib_producer_ctrl #(.SYNC_STAGES(3)) dut (
        .clock_1(clock_1), .reset(reset), .start(start), .burst_len(burst_len),
        .f_en(f_en), .f_valid(f_valid), .f_out(f_out), .req(req), .data_out(data_out),
        .ack(ack), .busy(busy), .done(done), .overflow(overflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clock_1) cyc <= cyc + 1;

    // Generator model: one word per f_en pulse, valid the following cycle, restarts on reset.
    always @(posedge clock_1 or posedge reset) begin
        if (reset) begin
            ga <= 0; gb <= 1; f_valid <= 0; f_out <= 0;
        end else begin
            f_valid <= f_en;
            if (f_en) begin
                f_out <= ga; ga <= gb; gb <= ga + gb; fen_cnt <= fen_cnt + 1;
            end
        end
    end

    always @(negedge clock_1) begin
        if (reset) begin
            cs = 0; ack = 0; ccnt = 0;
        end else case (cs)
            0: if (req) begin ccnt = 0; cs = 1; end
            1: begin ccnt++; if (ccnt >= ack_dly) begin ack = 1; ack_cyc = cyc; cs = 2; end end
            2: if (!req) begin ccnt = 0; cs = 3; end
            default: begin ccnt++; if (ccnt >= rel_dly) begin ack = 0; cs = 0; end end
        endcase
    end

    always @(negedge clock_1) begin
        if (req && !req_q) begin
            words++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_word: got %0d expected none", data_out);
            end else chk("word", data_out, exp_q.pop_front());
            held = data_out;
        end else if (req && req_q) chk("data_stable", data_out, held);
        if (!req && req_q) fall_cyc = cyc;
        if (done) done_cnt++;
        req_q = req;
    end

    task automatic burst(input int len, input int first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(fib[first+i]);
        @(negedge clock_1); start = 1; burst_len = 5'(len);
        @(negedge clock_1); start = 0;
    endtask

    task automatic wait_done(input string name, input int dstart);
        int tt = 0;
        while (done_cnt == dstart && tt < 2000) begin @(negedge clock_1); tt++; end
        chk({name, "_done"}, done_cnt - dstart, 1);
        @(negedge clock_1);
        chk({name, "_busy"}, 32'(busy), 0);
        repeat (5) @(negedge clock_1);
        chk({name, "_done_once"}, done_cnt - dstart, 1);
        chk({name, "_queue"}, exp_q.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge clock_1);
        chk("rst_f_en", 32'(f_en), 0);
        chk("rst_req", 32'(req), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ovf", 32'(overflow), 0);
        reset = 0;

        f0 = fen_cnt; d0 = done_cnt; w0 = words;
        burst(5, 0, 5);
        wait_done("b5", d0);
        chk("b5_words", words - w0, 5);
        chk("b5_fen", fen_cnt - f0, 5);
        chk("b5_ovf", 32'(overflow), 0);

        d0 = done_cnt; w0 = words;
        burst(3, 5, 3);
        wait_done("b3", d0);
        chk("b3_words", words - w0, 3);
        chk("b3_last", 32'(data_out), 13);

        ack_dly = 20; d0 = done_cnt;
        burst(1, 8, 1);
        wait_done("slow", d0);
        chk("slow_req_fall_lat", fall_cyc - ack_cyc, 4);
        ack_dly = 3;

        d0 = done_cnt; w0 = words;
        burst(4, 9, 4);
        repeat (5) begin
            repeat (4) @(negedge clock_1);
            start = 1; burst_len = 5'd7;
            @(negedge clock_1); start = 0;
        end
        wait_done("b4", d0);
        chk("b4_words", words - w0, 4);

        @(negedge clock_1); reset = 1;
        @(negedge clock_1); reset = 0;
        exp_q.delete();
        w0 = words;
        burst(10, 0, 7);
        t = 0;
        while (!(words == w0 + 6 && ack) && t < 2000) begin @(negedge clock_1); t++; end
        ack_dly = 1000;
        t = 0;
        while (!(words == w0 + 7) && t < 2000) begin @(negedge clock_1); t++; end
        chk("mid_words", words - w0, 7);
        chk("mid_data", 32'(data_out), 8);
        #2 reset = 1;
        #1;
        chk("mid_rst_req", 32'(req), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_data", 32'(data_out), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        @(negedge clock_1); reset = 0; ack_dly = 3;
        d0 = done_cnt; w0 = words;
        burst(2, 0, 2);
        wait_done("restart", d0);
        chk("restart_words", words - w0, 2);
        chk("restart_last", 32'(data_out), 1);

        @(negedge clock_1); reset = 1;
        @(negedge clock_1); reset = 0;
        f0 = fen_cnt; d0 = done_cnt; w0 = words;
        burst(0, 0, 25);
        wait_done("wrap", d0);
        chk("wrap_words", words - w0, 25);
        chk("wrap_fen", fen_cnt - f0, 26);
        chk("wrap_ovf", 32'(overflow), 1);
        chk("wrap_last", 32'(data_out), 46368);

        f0 = fen_cnt;
        @(negedge clock_1); start = 1; burst_len = 5'd3;
        @(negedge clock_1); start = 0;
        repeat (3) @(negedge clock_1);
        chk("ovf_start_busy", 32'(busy), 0);
        chk("ovf_start_fen", fen_cnt - f0, 0);
        chk("ovf_sticky", 32'(overflow), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
